// File: rtl/iterative_shifter.sv
// iterative_shifter
//   Multi-cycle barrel shifter. A request is captured in IDLE, then the shift
//   amount is resolved STAGES_PER_CYCLE barrel stages per clock in BUSY, and
//   the registered result is held in DONE until the consumer takes it.
//   Operations: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   request handshake (in_data, in_shamt, in_op)
//   abort               cancel the operation in BUSY or DONE
//   out_valid/out_ready result handshake (out_data, out_zero)
//   busy                high while iterating
module iterative_shifter #(
    parameter int WIDTH            = 32,
    parameter int SHAMT_W          = 5,
    parameter int STAGES_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    input  logic               abort,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_zero,
    output logic               busy
);

    localparam int S  = STAGES_PER_CYCLE;
    localparam int N  = (SHAMT_W + S - 1) / S;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic               finish;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] shamt;
    logic [1:0]         op;
    logic               fill;
    logic [KW-1:0]      k;
    logic [WIDTH-1:0]   stage_out;

    // Apply every barrel stage belonging to iteration k. Stage j moves the
    // word by 2^j when shamt[j] is set; 2^j < WIDTH so ROR/SRA never shift
    // by the full width.
    function automatic logic [WIDTH-1:0] apply_stages(
        input logic [WIDTH-1:0]   d,
        input logic [SHAMT_W-1:0] sh,
        input logic [1:0]         o,
        input logic               f,
        input logic [KW-1:0]      it
    );
        logic [WIDTH-1:0] r;
        r = d;
        for (int j = 0; j < SHAMT_W; j++) begin
            if ((KW'(j / S) == it) && sh[j]) begin
                case (o)
                    2'b00:   r = r << (1 << j);
                    2'b01:   r = r >> (1 << j);
                    2'b10:   r = (r >> (1 << j)) | ({WIDTH{f}} << (WIDTH - (1 << j)));
                    2'b11:   r = (r >> (1 << j)) | (r << (WIDTH - (1 << j)));
                    default: r = r;
                endcase
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    assign stage_out = apply_stages(work, shamt, op, fill, k);

    // Handshake flags decoded from the state register; in_ready is also
    // masked by rst so nothing looks acceptable while reset is held.
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort is only honoured outside IDLE and wins over a
    // finishing iteration so a cancelled result is never published.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = BUSY;
                    accept     = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            BUSY: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (k == K_LAST) begin
                    state_next = DONE;
                    finish     = 1'b1;
                end else begin
                    state_next = BUSY;
                end
            end
            DONE: begin
                if (abort || out_ready) begin
                    state_next = IDLE;
                end else begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, iteration and result registers. The SRA fill bit is
    // latched from the original operand so later stages keep the true sign.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work     <= {WIDTH{1'b0}};
            shamt    <= {SHAMT_W{1'b0}};
            op       <= 2'b00;
            fill     <= 1'b0;
            k        <= {KW{1'b0}};
            out_data <= {WIDTH{1'b0}};
            out_zero <= 1'b1;
        end else if (accept) begin
            work  <= in_data;
            shamt <= in_shamt;
            op    <= in_op;
            fill  <= in_data[WIDTH-1];
            k     <= {KW{1'b0}};
        end else if ((state == BUSY) && !abort) begin
            work <= stage_out;
            k    <= k + KW'(1);
            if (finish) begin
                out_data <= stage_out;
                out_zero <= ~|stage_out;
            end else begin
                out_data <= out_data;
            end
        end else begin
            work <= work;
        end
    end

endmodule

// File: tb/tb_iterative_shifter.sv
module tb_iterative_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_op;
    logic        abort;
    logic        out_ready;

    logic        in_ready1, out_valid1, out_zero1, busy1;
    logic [31:0] out_data1;
    logic        in_ready2, out_valid2, out_zero2, busy2;
    logic [31:0] out_data2;
    logic        in_ready5, out_valid5, out_zero5, busy5;
    logic [31:0] out_data5;

    int checks = 0;
    int errors = 0;
    int lat1, lat2, lat5, busy_cnt;
    logic [31:0] last_exp;

    always #5 clk = ~clk;

    iterative_shifter #(.WIDTH(32), .SHAMT_W(5), .STAGES_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .abort(abort),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .out_zero(out_zero1), .busy(busy1));

    iterative_shifter #(.WIDTH(32), .SHAMT_W(5), .STAGES_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .abort(abort),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .out_zero(out_zero2), .busy(busy2));

    iterative_shifter #(.WIDTH(32), .SHAMT_W(5), .STAGES_PER_CYCLE(5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready5),
        .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .abort(abort),
        .out_valid(out_valid5), .out_ready(out_ready), .out_data(out_data5),
        .out_zero(out_zero5), .busy(busy5));

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                              input logic [4:0] sh);
        logic [63:0] dd;
        dd = {d, d} >> sh;
        case (op)
            2'b00:   return d << sh;
            2'b01:   return d >> sh;
            2'b10:   return 32'($signed(d) >>> sh);
            default: return dd[31:0];
        endcase
    endfunction

    // Issue one request (all instances start in IDLE), then watch 8 edges
    // with out_ready low, recording the first edge each out_valid appears.
    task automatic run_op(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh);
        in_op = op; in_data = d; in_shamt = sh; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = $urandom; in_shamt = 5'($urandom); in_op = 2'($urandom);
        lat1 = 99; lat2 = 99; lat5 = 99; busy_cnt = 0;
        if (busy1) busy_cnt++;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (out_valid1 && lat1 == 99) lat1 = c;
            if (out_valid2 && lat2 == 99) lat2 = c;
            if (out_valid5 && lat5 == 99) lat5 = c;
            if (busy1) busy_cnt++;
        end
    endtask

    task automatic deliver();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; in_shamt = 5'd0; in_op = 2'b00;
        abort = 1'b0; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (out_valid1 !== 1'b0 || busy1 !== 1'b0 || out_data1 !== 32'h0 || in_ready1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got v=%b b=%b d=%h r=%b want 0 0 00000000 0",
                     out_valid1, busy1, out_data1, in_ready1);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready1 !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b want 1", in_ready1);
        end
    endtask

    task automatic directed(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh,
                            input logic [31:0] exp);
        run_op(op, d, sh);
        checks++;
        if (out_data1 !== exp || out_data2 !== exp || out_data5 !== exp) begin
            errors++;
            $display("FAIL dir_data op=%0d d=%h sh=%0d got %h/%h/%h want %h",
                     op, d, sh, out_data1, out_data2, out_data5, exp);
        end
        checks++;
        if (out_zero1 !== (exp == 32'h0)) begin
            errors++; $display("FAIL dir_zero got %b want %b", out_zero1, (exp == 32'h0));
        end
        checks++;
        if (lat1 !== 5 || lat2 !== 3 || lat5 !== 1) begin
            errors++; $display("FAIL dir_latency got %0d/%0d/%0d want 5/3/1", lat1, lat2, lat5);
        end
        checks++;
        if (busy_cnt !== 5) begin
            errors++; $display("FAIL dir_busy got %0d want 5", busy_cnt);
        end
        last_exp = exp;
        deliver();
    endtask

    task automatic test_ops();
        directed(2'b01, 32'h80000000, 5'd31, 32'h00000001);
        directed(2'b10, 32'hF0000000, 5'd4,  32'hFF000000);
        directed(2'b10, 32'h70000000, 5'd4,  32'h07000000);
        directed(2'b00, 32'h00000001, 5'd31, 32'h80000000);
        directed(2'b01, 32'h00000001, 5'd1,  32'h00000000);
        directed(2'b11, 32'h12345678, 5'd8,  32'h78123456);
        directed(2'b11, 32'h12345678, 5'd0,  32'h12345678);
        directed(2'b00, 32'hA5A5A5A5, 5'd16, 32'hA5A50000);
        directed(2'b10, 32'h80000001, 5'd31, 32'hFFFFFFFF);
    endtask

    task automatic test_backpressure();
        int waited;
        run_op(2'b01, 32'h000000F0, 5'd4);
        in_op = 2'b00; in_data = 32'h00000001; in_shamt = 5'd1; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid1 !== 1'b1 || out_data1 !== 32'h0000000F || in_ready1 !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold got v=%b d=%h r=%b want 1 0000000f 0",
                         out_valid1, out_data1, in_ready1);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
            errors++; $display("FAIL bp_release got v=%b r=%b want 0 1", out_valid1, in_ready1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (busy1 !== 1'b1) begin
            errors++; $display("FAIL bp_accept got busy=%b want 1", busy1);
        end
        waited = 0;
        while (!out_valid1 && waited < 10) begin
            @(posedge clk); #1; waited++;
        end
        checks++;
        if (out_valid1 !== 1'b1 || out_data1 !== 32'h00000002) begin
            errors++; $display("FAIL bp_result got v=%b d=%h want 1 00000002", out_valid1, out_data1);
        end
        last_exp = 32'h00000002;
        @(posedge clk); @(posedge clk); #1;
        deliver();
    endtask

    task automatic test_abort();
        int seen;
        in_op = 2'b00; in_data = 32'h0000FFFF; in_shamt = 5'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (busy1 !== 1'b0 || in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got b=%b r=%b v=%b want 0 1 0", busy1, in_ready1, out_valid1);
        end
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (out_valid1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL abort_no_valid got %0d valid cycles want 0", seen);
        end
        checks++;
        if (out_data1 !== last_exp) begin
            errors++; $display("FAIL abort_keep got %h want %h", out_data1, last_exp);
        end
        // abort together with a request in IDLE: request wins
        in_op = 2'b01; in_data = 32'h00000100; in_shamt = 5'd8; in_valid = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; abort = 1'b0;
        checks++;
        if (busy1 !== 1'b1) begin
            errors++; $display("FAIL abort_idle_accept got busy=%b want 1", busy1);
        end
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (out_valid1 !== 1'b1 || out_data1 !== 32'h00000001) begin
            errors++; $display("FAIL abort_idle_result got v=%b d=%h want 1 00000001", out_valid1, out_data1);
        end
        deliver();
    endtask

    task automatic test_reset_mid();
        in_op = 2'b11; in_data = 32'hDEADBEEF; in_shamt = 5'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid1 !== 1'b0 || busy1 !== 1'b0 || out_data1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid got v=%b b=%b d=%h want 0 0 00000000", out_valid1, busy1, out_data1);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        directed(2'b11, 32'h0000000F, 5'd4, 32'hF0000000);
    endtask

    task automatic test_sweep();
        logic [31:0] d, exp;
        for (int o = 0; o < 4; o++) begin
            for (int sh = 0; sh < 32; sh++) begin
                d = $urandom;
                exp = ref_shift(2'(o), d, 5'(sh));
                run_op(2'(o), d, 5'(sh));
                checks++;
                if (out_data1 !== exp || out_data2 !== exp || out_data5 !== exp) begin
                    errors++;
                    $display("FAIL sweep_data op=%0d sh=%0d d=%h got %h/%h/%h want %h",
                             o, sh, d, out_data1, out_data2, out_data5, exp);
                end
                checks++;
                if (lat1 !== 5 || lat2 !== 3 || lat5 !== 1) begin
                    errors++;
                    $display("FAIL sweep_latency op=%0d sh=%0d got %0d/%0d/%0d want 5/3/1",
                             o, sh, lat1, lat2, lat5);
                end
                deliver();
            end
        end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
